// File: rtl/uib_pkg.sv
// rtl/uib_pkg.sv - shared state encoding and default sizing for the uib arbiter
package uib_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } uib_state_t;

    localparam int UIB_N_MASTERS      = 4;
    localparam int UIB_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/uib_rr_pick.sv
// rtl/uib_rr_pick.sv - combinational round-robin winner search starting at ptr
module uib_rr_pick
    import uib_pkg::*;
#(
    parameter int N_MASTERS = UIB_N_MASTERS
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [$clog2(N_MASTERS)-1:0] ptr,
    output logic [$clog2(N_MASTERS)-1:0] winner,
    output logic                         found
);

    localparam int IW = $clog2(N_MASTERS);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Visit ptr, ptr+1, ... wrapping at N_MASTERS; the first requester seen wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            idx = IW'((sum >= (IW+1)'(N_MASTERS)) ? sum - (IW+1)'(N_MASTERS) : sum);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uib_arbiter.sv
// rtl/uib_arbiter.sv - round-robin uib bus arbiter; UIB_ARB_TIMEOUT_EN adds a BUSY timeout
module uib_arbiter
    import uib_pkg::*;
#(
    parameter int N_MASTERS      = UIB_N_MASTERS,
    parameter int TIMEOUT_CYCLES = UIB_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTERS-1:0]         req,
    input  logic                         sel_ready,
    output logic [N_MASTERS-1:0]         gnt,
    output logic [$clog2(N_MASTERS)-1:0] gnt_idx,
    output logic                         gnt_valid,
    output logic [N_MASTERS-1:0]         master_ready,
    output logic                         timeout_err
);

    localparam int IW = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uib_arbiter: parameter out of range");
    end

    uib_state_t    state_q;
    uib_state_t    state_d;
    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;
    logic          win_found;
    logic          ready_pulse;
    logic          tmo_pulse;
    logic          tmo_hit;

    uib_rr_pick #(
        .N_MASTERS(N_MASTERS)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .winner(win_idx),
        .found (win_found)
    );

`ifdef UIB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;

    // tmo_cnt holds the BUSY cycles already spent, so the current one is the limit at CNT-1.
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_q != BUSY) begin
            tmo_cnt <= '0;
        end else if (!sel_ready) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ready_pulse = 1'b0;
        tmo_pulse   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) state_d = BUSY;
            end
            BUSY: begin
                if (sel_ready) begin
                    ready_pulse = 1'b1;
                    state_d     = RELEASE;
                end else if (!req[gnt_idx]) begin
                    // Master abandoned its request: release silently.
                    state_d = RELEASE;
                end else if (tmo_hit) begin
                    ready_pulse = 1'b1;
                    tmo_pulse   = 1'b1;
                    state_d     = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_found) begin
                gnt     <= N_MASTERS'(1) << win_idx;
                gnt_idx <= win_idx;
                ptr     <= (win_idx == IW'(N_MASTERS - 1)) ? '0 : win_idx + IW'(1);
            end else if (state_d != BUSY) begin
                gnt     <= '0;
                gnt_idx <= '0;
            end
        end
    end

    assign gnt_valid    = |gnt;
    assign master_ready = (ready_pulse && !rst) ? gnt : '0;
    assign timeout_err  = tmo_pulse && !rst;

endmodule
